// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: shifts at most STEP positions per clock.
// A valid/ready handshake is used on both the operand and result sides.
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // One extra bit so that STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);

  function automatic logic [WIDTH-1:0] step_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic [SHAMT_W:0] s
  );
    logic [SHAMT_W:0] back;
    back = WIDTH_C - s;
    case (mode)
      MODE_SLL: step_shift = d << s;
      MODE_SRL: step_shift = d >> s;
      MODE_SRA: step_shift = $signed(d) >>> s;
      MODE_ROR: step_shift = (d >> s) | (d << back);
      default:  step_shift = d;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;

  logic [SHAMT_W:0]   rem_ext_s;
  logic [SHAMT_W:0]   step_s;
  logic               last_step_s;

  assign rem_ext_s   = {1'b0, rem_q};
  assign step_s      = (rem_ext_s < STEP_C) ? rem_ext_s : STEP_C;
  assign last_step_s = (rem_ext_s <= STEP_C);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= {WIDTH{1'b0}};
      rem_q   <= {SHAMT_W{1'b0}};
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_shamt;
          mode_d  = in_mode;
          state_d = (in_shamt == {SHAMT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // step_s never exceeds rem_q, so the truncation below is lossless.
        data_d = step_shift(data_q, mode_q, step_s);
        rem_d  = rem_q - step_s[SHAMT_W-1:0];
        if (last_step_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: table vectors, a full shamt sweep,
// back-pressure in DONE and a mid-operation reset.
module tb_iter_shifter;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] n,
                                            input logic [1:0] m);
    int nn;
    nn = int'(n);
    case (m)
      M_SLL:   ref_shift = x << nn;
      M_SRL:   ref_shift = x >> nn;
      M_SRA:   ref_shift = $signed(x) >>> nn;
      default: ref_shift = (nn == 0) ? x : ((x >> nn) | (x << (32 - nn)));
    endcase
  endfunction

  // Drive one operand with out_ready=1 and wait for its result pulse.
  task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                        input logic [31:0] exp, input string name);
    int k;
    @(negedge clk);
    check({name, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_mode   = m;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, (int'(sh) + 3) / 4);
    check({name, "_data"}, out_data, exp);
    @(negedge clk);
    check({name, "_pulse"}, {31'd0, out_valid}, 32'd0);
    check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] sweep_data[4];
  logic [31:0] held;
  int          k;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    vecs[0]  = '{32'h8000000A, 5'd5,  M_SRA, 32'hFC000000};
    vecs[1]  = '{32'hFFFFFFFF, 5'd31, M_SRL, 32'h00000001};
    vecs[2]  = '{32'hFFFFFFFF, 5'd31, M_SRA, 32'hFFFFFFFF};
    vecs[3]  = '{32'h00000001, 5'd31, M_SLL, 32'h80000000};
    vecs[4]  = '{32'h0000000F, 5'd4,  M_ROR, 32'hF0000000};
    vecs[5]  = '{32'h0004E721, 5'd0,  M_SLL, 32'h0004E721};
    vecs[6]  = '{32'h0004E721, 5'd0,  M_SRL, 32'h0004E721};
    vecs[7]  = '{32'h0004E721, 5'd0,  M_SRA, 32'h0004E721};
    vecs[8]  = '{32'h0004E721, 5'd0,  M_ROR, 32'h0004E721};
    vecs[9]  = '{32'h12345678, 5'd8,  M_ROR, 32'h78123456};
    vecs[10] = '{32'h12345678, 5'd12, M_SLL, 32'h45678000};
    vecs[11] = '{32'h80000000, 5'd1,  M_SRL, 32'h40000000};
    vecs[12] = '{32'h12345678, 5'd31, M_ROR, 32'h2468ACF0};
    sweep_data[0] = 32'h8000000A;
    sweep_data[1] = 32'd321313;
    sweep_data[2] = 32'hFFFFFFFF;
    sweep_data[3] = 32'd1;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_shamt  = 5'd0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].data, vecs[i].shamt, vecs[i].mode, vecs[i].exp, $sformatf("vec%0d", i));
    end

    for (int di = 0; di < 4; di++) begin
      for (int m = 0; m < 4; m++) begin
        for (int s = 0; s < 32; s++) begin
          run_op(sweep_data[di], 5'(s), 2'(m), ref_shift(sweep_data[di], 5'(s), 2'(m)),
                 $sformatf("sweep_d%0d_m%0d_s%0d", di, m, s));
        end
      end
    end

    // Back-pressure: result held in DONE, stray operand ignored.
    @(negedge clk);
    held      = ref_shift(32'hA5A50F0F, 5'd6, M_SRL);
    in_valid  = 1'b1;
    in_data   = 32'hA5A50F0F;
    in_shamt  = 5'd6;
    in_mode   = M_SRL;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("stall_latency", k, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall_data%0d", i), out_data, held);
      check($sformatf("stall_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
      in_valid = (i == 0);
      in_data  = 32'hDEADBEEF;
      in_shamt = 5'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall_valid_end", {31'd0, out_valid}, 32'd1);
    check("stall_data_end", out_data, held);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", {31'd0, out_valid}, 32'd0);
    check("stall_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("stall_stray_ignored", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset in the middle of a long shift.
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    in_shamt = 5'd20;
    in_mode  = M_SLL;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_shift_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_shift_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_out_data", out_data, 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_valid%0d", i), {31'd0, out_valid}, 32'd0);
    end
    run_op(32'h00000001, 5'd3, M_SLL, 32'h00000008, "post_rst_op");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
